// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, data-memory freeze and branch redirects.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_controller #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_branch_taken,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      freeze_back,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      redirect_fire,
  output logic [1:0]                ctl_state,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    REDIRECT = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   mem_stall;
  logic   load_use;

  assign mem_stall = mem_req_valid & ~mem_req_ready;
  assign load_use  = ex_mem_read & (ex_rd != '0) &
                     ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign ctl_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next state and control decode; priority is mem_stall > redirect > load_use.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    freeze_back   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    redirect_fire = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          freeze_back = 1'b1;
          pending_d   = ex_branch_taken;
          state_d     = MEM_WAIT;
        end else if (ex_branch_taken) begin
          flush_if_id   = 1'b1;
          flush_id_ex   = 1'b1;
          redirect_fire = 1'b1;
        end else if (load_use) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          freeze_back = 1'b1;
        end else begin
          state_d = pending_q ? REDIRECT : RUN;
        end
      end
      REDIRECT: begin
        // A new memory stall defers the flush; pending stays set until it issues.
        if (mem_stall) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          freeze_back = 1'b1;
        end else begin
          flush_if_id   = 1'b1;
          flush_id_ex   = 1'b1;
          redirect_fire = 1'b1;
          pending_d     = 1'b0;
          state_d       = RUN;
        end
      end
      default: begin
        pending_d = 1'b0;
        state_d   = RUN;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_pc)      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    if (redirect_fire) flush_count_d  = flush_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
